// File: rtl/clk_enable_gen.sv
// Runtime-programmable clock divider producing a pixel-rate tick strobe,
// a registered near-50% divided clock and the current phase count.
module clk_enable_gen #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             clk_div,
  output logic             pending,
  output logic [WIDTH-1:0] cnt
);

  localparam int DEF_I = (DEFAULT_DIV == 0) ? 1 : DEFAULT_DIV;
  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEF_I);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_pval;
  logic             r_pend;
  logic             r_tick;
  logic             r_clk_div;

  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0] w_din;
  logic [WIDTH:0]   w_half;
  logic             w_clk_nxt;

  always_comb begin
    w_wrap    = 1'b0;
    w_cnt_nxt = r_cnt;
    w_div_nxt = r_div;
    w_din     = (div_in == '0) ? ONE : div_in;
    if (en) begin
      w_wrap = (r_cnt == (r_div - ONE));
      if (w_wrap) begin
        w_cnt_nxt = '0;
        if (r_pend) w_div_nxt = r_pval;
      end else begin
        w_cnt_nxt = r_cnt + ONE;
      end
    end
    // Extra bit keeps D=2^WIDTH-1 from overflowing the half-period.
    w_half    = ({1'b0, w_div_nxt} + ONE_X) >> 1;
    w_clk_nxt = ({1'b0, w_cnt_nxt} < w_half);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_div     <= DEF_D;
      r_pval    <= '0;
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_clk_div <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_tick    <= w_wrap;
      r_clk_div <= w_clk_nxt;
      if (div_load) begin
        r_pval <= w_din;
        r_pend <= 1'b1;
      end else if (w_wrap) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign tick    = r_tick;
  assign clk_div = r_clk_div;
  assign pending = r_pend;
  assign cnt     = r_cnt;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: directed scenarios plus random
// stimulus checked against a period-level behavioural model.
module tb_clk_enable_gen;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         tick;
  logic         clk_div;
  logic         pending;
  logic [W-1:0] cnt;

  clk_enable_gen #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .tick    (tick),
    .clk_div (clk_div),
    .pending (pending),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int tick;
    int clk_div;
    int pending;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: divisor, phase within the period, queue of at most one
  // waiting divisor (last load wins).
  int m_d;
  int m_ph;
  int m_tick;
  int m_pend_q[$];

  function automatic int sat(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void model_step(input bit r, input bit e,
                                     input bit ld, input int din);
    if (r) begin
      m_d  = sat(4);
      m_ph = 0;
      m_tick = 0;
      m_pend_q.delete();
      return;
    end
    m_tick = 0;
    if (e) begin
      m_ph = m_ph + 1;
      if (m_ph == m_d) begin
        m_ph   = 0;
        m_tick = 1;
        if (m_pend_q.size() > 0) m_d = m_pend_q.pop_front();
      end
    end
    if (ld) begin
      m_pend_q.delete();
      m_pend_q.push_back(sat(din));
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit ld, input int din);
    exp_t x;
    @(negedge clk);
    rst      = r;
    en       = e;
    div_load = ld;
    div_in   = W'(din);
    model_step(r, e, ld, din);
    x.cnt     = m_ph;
    x.tick    = m_tick;
    x.clk_div = (m_ph < (m_d + 1) / 2) ? 1 : 0;
    x.pending = (m_pend_q.size() > 0) ? 1 : 0;
    exp_q.push_back(x);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
  endtask

  task automatic run_until(input int ph);
    for (int i = 0; i < 600 && m_ph != ph; i++) cyc(0, 1, 0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("cnt", int'(cnt), x.cnt);
        chk("tick", int'(tick), x.tick);
        chk("clk_div", int'(clk_div), x.clk_div);
        chk("pending", int'(pending), x.pending);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
    m_d = 4; m_ph = 0; m_tick = 0;
    // Reset and default D=4 counting
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    run(13);
    // Load 3 mid-period: old period completes first
    run_until(1);
    cyc(0, 1, 1, 3);
    run(12);
    // Freeze for two cycles at phase 2
    run_until(2);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    run(10);
    // Load 0 gives D=1, then the maximum divisor
    cyc(0, 1, 1, 0);
    run(8);
    cyc(0, 1, 1, 255);
    run(530);
    // Two loads before a wrap, then a load on the wrap cycle
    run_until(10);
    cyc(0, 1, 1, 5);
    cyc(0, 1, 1, 6);
    run_until(0);
    run(14);
    run_until(5);
    cyc(0, 1, 1, 7);
    run(20);
    // Load while disabled
    cyc(0, 0, 1, 2);
    cyc(0, 0, 0, 0);
    run(12);
    // Reset with a load pending
    run_until(0);
    run_until(1);
    cyc(0, 1, 1, 9);
    cyc(1, 1, 0, 0);
    run(12);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3)
        cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5);
      else if (r < 40)
        cyc(0, 1'(r & 1), 1, int'($urandom_range(0, 9)));
      else if (r < 42)
        cyc(0, 1, 1, int'($urandom_range(200, 255)));
      else if (r < 200)
        cyc(0, 0, 0, 0);
      else
        cyc(0, 1, 0, int'($urandom_range(0, 255)));
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
